// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the MEM-stage core access and a dma/debug loader.
// The core has fixed priority; a starvation counter opens a short forced stall window for the dma.
module dmem_port_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int FORCE_BEATS  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_mem_read,
   input  logic        core_mem_write,
   input  logic [7:0]  core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        dma_valid,
   input  logic        dma_we,
   input  logic [7:0]  dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_ready,
   output logic [31:0] dma_rdata,
   output logic        dma_rvalid,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   localparam logic [3:0] BEATS = 4'(FORCE_BEATS);

   typedef enum logic {ARB, FORCE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  starve_cnt, starve_nxt;
   logic [3:0]  beat_cnt, beat_nxt;
   logic        core_acc;
   logic        hs;

   assign core_acc   = core_mem_read | core_mem_write;
   assign hs         = dma_valid & dma_ready;
   assign core_rdata = mem_rdata;

   // Port ownership: core in ARB when it accesses, dma otherwise; idle port follows the core.
   always_comb begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = 1'b0;
      dma_ready = 1'b0;
      if (state == ARB && core_acc) begin
         mem_we = core_mem_write;
      end else begin
         dma_ready = dma_valid;
         if (dma_valid) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      beat_nxt   = beat_cnt;
      case (state)
         ARB: begin
            if (dma_valid && !dma_ready) begin
               if (starve_cnt >= LIMIT - 8'd1) begin
                  starve_nxt = LIMIT;
                  state_nxt  = FORCE;
               end else begin
                  starve_nxt = starve_cnt + 8'd1;
               end
            end else begin
               starve_nxt = 8'd0;
            end
         end
         FORCE: begin
            // Window closes when the dma goes quiet or has used its beat budget.
            if (!dma_valid || (hs && beat_cnt == BEATS - 4'd1)) begin
               state_nxt  = ARB;
               starve_nxt = 8'd0;
               beat_nxt   = 4'd0;
            end else if (hs) begin
               beat_nxt = beat_cnt + 4'd1;
            end
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB;
         starve_cnt <= 8'd0;
         beat_cnt   <= 4'd0;
         core_stall <= 1'b0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= 32'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         beat_cnt   <= beat_nxt;
         core_stall <= (state_nxt == FORCE);
         dma_rvalid <= hs & ~dma_we;
         if (hs && !dma_we)
            dma_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a cycle-level behavioural model with its own memory image.
module tb_dmem_port_arbiter;

   localparam int SL = 8;
   localparam int FB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_mem_read, core_mem_write;
   logic [7:0]  core_addr;
   logic [31:0] core_wdata, core_rdata;
   logic        core_stall;
   logic        dma_valid, dma_we;
   logic [7:0]  dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_ready;
   logic [31:0] dma_rdata;
   logic        dma_rvalid;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   dmem_port_arbiter #(.STARVE_LIMIT(SL), .FORCE_BEATS(FB)) dut (
      .clk(clk), .reset(reset),
      .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
      .core_stall(core_stall),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // stimulus for the next cycle
   logic        c_rd, c_wr, d_v, d_we, rst;
   logic [7:0]  c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;

   // behavioural model
   logic [31:0] ref_mem [256];
   bit          m_force, m_rvalid, last_hs;
   int          m_starve, m_beats;
   logic [31:0] m_rdata;
   int          total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      bit acc, own_core, e_ready, e_we, hs;
      logic [7:0]  e_addr;
      logic [31:0] e_data;
      core_mem_read = c_rd; core_mem_write = c_wr; core_addr = c_addr; core_wdata = c_wdata;
      dma_valid = d_v; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
      reset = rst;
      @(negedge clk);
      acc      = c_rd | c_wr;
      own_core = !m_force && acc;
      e_ready  = own_core ? 1'b0 : d_v;
      e_we     = own_core ? c_wr : (d_v & d_we);
      e_addr   = own_core ? c_addr : d_addr;
      e_data   = own_core ? c_wdata : d_wdata;
      chk("core_stall", {31'd0, core_stall}, {31'd0, m_force});
      chk("dma_ready", {31'd0, dma_ready}, {31'd0, e_ready});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (own_core || d_v) chk("mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
      if (e_we) chk("mem_wdata", mem_wdata, e_data);
      chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rvalid});
      chk("dma_rdata", dma_rdata, m_rdata);
      if (own_core && c_rd && !c_wr) chk("core_rdata", core_rdata, ref_mem[c_addr]);
      hs = d_v & e_ready;
      if (rst) begin
         m_force = 0; m_starve = 0; m_beats = 0; m_rvalid = 0; m_rdata = 32'd0;
      end else begin
         m_rvalid = hs & !d_we;
         if (m_rvalid) m_rdata = ref_mem[d_addr];
         if (!m_force) begin
            if (d_v && !e_ready) begin
               m_starve = m_starve + 1;
               if (m_starve >= SL) begin m_starve = SL; m_force = 1; end
            end else m_starve = 0;
         end else begin
            if (hs) m_beats++;
            if ((hs && m_beats == FB) || !d_v) begin
               m_force = 0; m_starve = 0; m_beats = 0;
            end
         end
      end
      if (e_we) ref_mem[e_addr] = e_data;
      last_hs = hs;
      @(posedge clk); #1;
   endtask

   task automatic run_rand(input int n, input int pc, input int pd, input int pr);
      for (int i = 0; i < n; i++) begin
         rst = ($urandom_range(99) < pr);
         if (!m_force) begin
            if ($urandom_range(99) < pc) begin
               case ($urandom_range(2))
                  0: begin c_rd = 1; c_wr = 0; end
                  1: begin c_rd = 0; c_wr = 1; end
                  default: begin c_rd = 1; c_wr = 1; end
               endcase
            end else begin
               c_rd = 0; c_wr = 0;
            end
            c_addr = 8'($urandom_range(15)); c_wdata = $urandom;
         end
         if (!(d_v && !last_hs)) begin
            d_v = ($urandom_range(99) < pd); d_we = 1'($urandom_range(1));
            d_addr = 8'($urandom_range(15)); d_wdata = $urandom;
         end
         cycle();
      end
   endtask

   task automatic idle();
      c_rd = 0; c_wr = 0; d_v = 0; d_we = 0; rst = 0;
   endtask

   task automatic hold_until_force();
      c_rd = 0; c_wr = 1; c_addr = 8'h30; c_wdata = 32'hC0C0_0001;
      d_v = 1; d_we = 1; d_addr = 8'h31; d_wdata = 32'h0D0D_0001;
      for (int k = 0; k < 20 && !m_force; k++) cycle();
      chk("reach_force", {31'd0, core_stall}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom; ref_mem[i] = mem[i];
      end
      c_addr = 0; c_wdata = 0; d_addr = 0; d_wdata = 0;
      idle();
      rst = 1; reset = 1;
      core_mem_read = 0; core_mem_write = 0; core_addr = 0; core_wdata = 0;
      dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      m_force = 0; m_starve = 0; m_beats = 0; m_rvalid = 0; m_rdata = 0; last_hs = 0;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      rst = 0;

      // core store then load with a competing dma read
      c_wr = 1; c_addr = 8'h10; c_wdata = 32'hDEADBEEF;
      d_v = 1; d_we = 0; d_addr = 8'h05;
      cycle();
      c_wr = 0; c_rd = 1;
      cycle();
      chk("t1_load", core_rdata, 32'hDEADBEEF);
      idle(); cycle();

      // dma write then read back with core idle
      d_v = 1; d_we = 1; d_addr = 8'h22; d_wdata = 32'h12345678;
      cycle();
      d_we = 0;
      cycle();
      idle(); cycle();
      chk("t2_rdata", dma_rdata, 32'h12345678);

      // starvation: both held, stall at cycle 9 for exactly FB beats
      c_wr = 1; c_addr = 8'h40; c_wdata = 32'hAAAA5555;
      d_v = 1; d_we = 1; d_addr = 8'h41; d_wdata = 32'h5555AAAA;
      for (int i = 0; i < 16; i++) begin
         d_wdata = $urandom;
         cycle();
         if (i == 7)  chk("t3_stall_rise", {31'd0, core_stall}, 32'd1);
         if (i == 11) chk("t3_stall_fall", {31'd0, core_stall}, 32'd0);
      end
      idle(); cycle();

      // dma drops after 2 beats in the window
      hold_until_force();
      cycle(); cycle();
      d_v = 0;
      cycle();
      chk("t4_exit", {31'd0, core_stall}, 32'd0);
      idle(); cycle();

      // reset during the window after one beat
      hold_until_force();
      cycle();
      rst = 1;
      cycle();
      rst = 0; d_v = 0; c_wr = 0; c_rd = 1; c_addr = 8'h10;
      cycle();
      chk("t5_after_rst", {31'd0, core_stall}, 32'd0);
      idle(); cycle();

      // alternate core and dma every cycle
      for (int i = 0; i < 20; i++) begin
         c_rd = (i % 2 == 0); c_wr = 0; c_addr = 8'(i);
         d_v = (i % 2 == 1); d_we = 1'($urandom_range(1)); d_addr = 8'(i + 1); d_wdata = $urandom;
         cycle();
      end
      idle(); cycle();

      run_rand(400, 50, 50, 0);
      run_rand(300, 90, 90, 1);
      run_rand(300, 0, 80, 0);
      run_rand(300, 80, 20, 2);
      run_rand(400, 100, 100, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single 256x32 data memory port between the pipeline MEM stage ("core") and a DMA/debug loader ("dma").
- The core has fixed priority and is never delayed in normal operation.
- The dma side uses a per-word valid/ready handshake.
- A starvation counter forces a short core stall window so dma traffic always makes progress.
- Memory model: combinational read, write on posedge clk when mem_we=1.

Parameters:
- STARVE_LIMIT, 8: consecutive blocked dma cycles before a forced stall window (legal range 1-255).
- FORCE_BEATS, 4: maximum dma handshakes granted per stall window (legal range 1-15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_mem_read  in  1  MEM-stage load
- core_mem_write  in  1  MEM-stage store
- core_addr  in  8  MEM-stage word address
- core_wdata  in  32  store data
- core_rdata  out  32  load data (combinational from mem_rdata)
- core_stall  out  1  registered; pipeline must hold all stages while 1
- dma_valid  in  1  dma request pending
- dma_we  in  1  1=write, 0=read
- dma_addr  in  8  dma word address
- dma_wdata  in  32  dma write data
- dma_ready  out  1  combinational; handshake completes when dma_valid&dma_ready
- dma_rdata  out  32  registered read data
- dma_rvalid  out  1  registered; one-cycle pulse the cycle after a read handshake
- mem_addr  out  8  to data memory
- mem_wdata  out  32  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  32  from data memory

Behaviour:
- Definition: core_acc = core_mem_read | core_mem_write.
- Reset: state=ARB, starve_cnt=0, beat_cnt=0, core_stall=0, dma_rvalid=0, dma_rdata=0. The comb outputs then follow the ARB rules.
- ARB state:
  - If core_acc: mem port driven by the core (mem_we=core_mem_write); dma_ready=0.
  - Else: dma_ready=dma_valid; mem port driven by dma (mem_we=dma_valid&dma_we).
  - If nothing is active: mem_we=0 and mem_addr/mem_wdata follow the core inputs.
- starve_cnt (ARB only):
  - Increments when dma_valid & ~dma_ready, saturating at STARVE_LIMIT.
  - Clears on any dma handshake or when dma_valid=0.
  - When the blocked increment makes starve_cnt reach STARVE_LIMIT, the next state is FORCE and core_stall<=1 on the same edge.
- FORCE state (core_stall=1):
  - Core inputs are ignored; the core holds its MEM-stage request unchanged.
  - dma_ready=dma_valid and the dma owns the mem port.
  - beat_cnt increments per handshake.
  - Exit to ARB when beat_cnt reaches FORCE_BEATS on a handshake, or when dma_valid=0.
  - On exit: core_stall<=0, starve_cnt<=0, beat_cnt<=0.
  - On the first ARB cycle after exit, the held core request is serviced normally.
- dma read handshake: dma_rdata<=mem_rdata and dma_rvalid<=1 at that edge. Otherwise dma_rvalid<=0 and dma_rdata holds.
- core_rdata = mem_rdata at all times. It is meaningful only in ARB cycles with core_mem_read=1.
- Simultaneous core_acc and dma_valid in ARB: the core wins and the dma is counted as blocked.
- Same address from both sides in the same cycle: no conflict is possible, because only one side owns the port.
- Reset in FORCE: the state returns to ARB and core_stall=0 in the first cycle after the reset edge.
  - Any handshake in the reset cycle is still a comb handshake, but the dma must treat reset as aborting it.
  - dma_rvalid=0 after reset.
- Both core_mem_read and core_mem_write set: treated as a store (mem_we=1).

Test Plan:
- Core store addr 0x10 data 0xDEADBEEF, then load 0x10 → mem_we=1 in the store cycle; core_rdata=0xDEADBEEF in the load cycle; dma_ready=0 while core_acc=1.
- Core idle, dma write 0x22←0x12345678, then dma read 0x22 → dma_ready=1 in each cycle; dma_rvalid pulses 1 cycle after the read handshake with dma_rdata=0x12345678; core_stall stays 0.
- core_acc held high and dma_valid held high, STARVE_LIMIT=8 → dma_ready=0 for 8 cycles; core_stall=1 from cycle 9 for exactly 4 handshakes (FORCE_BEATS=4); then core_stall=0 and the core regains the port.
- In FORCE, dma_valid drops after 2 beats → core_stall deasserts on the next edge; starve_cnt=0.
- Assert reset during FORCE after 1 beat → next cycle core_stall=0, dma_rvalid=0; state is ARB (core access is immediately honoured).
- Alternate core_acc and dma_valid each cycle → dma is serviced in the core-idle cycles; starve_cnt never exceeds 1; core_stall never asserts.
